// File: rtl/fetch_queue.sv
// fetch_queue: PC generator feeding a 4-entry instruction queue with redirect flush
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_adr,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        deq,
    output logic [31:0] inst,
    output logic [31:0] inst_pc4,
    output logic        inst_valid,
    output logic [2:0]  count
);
    localparam logic [2:0] FULL = 3'(DEPTH);
    logic [63:0] mem [4];
    logic [31:0] pc, pc_nxt, pc4;
    logic [1:0]  rd, wr, rd_nxt, wr_nxt;
    logic [2:0]  count_nxt;
    logic        enq, dq;
    assign pc4 = pc + 32'd4;
    // full blocks enqueue even when a dequeue frees a slot on the same edge
    always_comb begin
        enq       = !redirect && count != FULL;
        dq        = !redirect && deq && count != 3'd0;
        pc_nxt    = redirect ? {redirect_pc[31:2], 2'b00} : enq ? pc4 : pc;
        wr_nxt    = redirect ? 2'd0 : enq ? wr + 2'd1 : wr;
        rd_nxt    = redirect ? 2'd0 : dq ? rd + 2'd1 : rd;
        count_nxt = redirect ? 3'd0 : (enq && !dq) ? count + 3'd1 : (dq && !enq) ? count - 3'd1 : count;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc    <= RESET_PC;
            rd    <= 2'd0;
            wr    <= 2'd0;
            count <= 3'd0;
        end else begin
            pc    <= pc_nxt;
            rd    <= rd_nxt;
            wr    <= wr_nxt;
            count <= count_nxt;
        end
    end
    always_ff @(posedge clk)
        if (enq) mem[wr] <= {pc4, imem_data};
    always_comb begin
        imem_adr   = pc;
        inst_valid = count != 3'd0;
        inst_pc4   = inst_valid ? mem[rd][63:32] : 32'd0;
        inst       = inst_valid ? mem[rd][31:0] : 32'd0;
    end
endmodule
